// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master side issues start with its operands. The slave side returns the
// busy/done handshake together with the result and its flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, a, b, bin, signed_mode,
    input  busy, done, diff, bout, zero, neg, ovf
  );

  modport slave (
    input  start, a, b, bin, signed_mode,
    output busy, done, diff, bout, zero, neg, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor that computes a - b - bin, LSB digit first.
// Each clock it processes one DIGIT-wide slice of full-subtractor cells.
// The borrow between slices is carried in a flip-flop.
// Results and flags are registered once, on the final digit, and then hold
// until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_signed;
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  logic [DIGIT-1:0] w_digit;
  logic             w_borrowOut;
  logic [WIDTH-1:0] w_nextShift;
  logic             w_lastDigit;
  logic             w_resMsb;

  // Ripple the borrow through one DIGIT-wide slice of full-subtractor cells.
  // The slice takes the low bits of the working operands as input.
  always_comb begin : slice
    logic c;
    c       = r_borrow;
    w_digit = '0;
    for (int i = 0; i < DIGIT; i++) begin
      w_digit[i] = r_a[i] ^ r_b[i] ^ c;
      c          = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & c);
    end
    w_borrowOut = c;
  end

  // New digits enter from the MSB side. After N digits, the register holds
  // the complete difference.
  assign w_nextShift = (r_shift >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));
  assign w_lastDigit = (r_cnt == LAST);
  assign w_resMsb    = w_nextShift[WIDTH-1];

  // Two-state control: latch operands on start, then step one digit per
  // clock and publish the result and flags on the final digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_signed <= 1'b0;
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_signed <= bus.signed_mode;
            r_aMsb   <= bus.a[WIDTH-1];
            r_bMsb   <= bus.b[WIDTH-1];
            r_cnt    <= '0;
            r_shift  <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_shift  <= w_nextShift;
          r_borrow <= w_borrowOut;
          r_cnt    <= r_cnt + 1'b1;
          if (w_lastDigit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_diff  <= w_nextShift;
            r_bout  <= w_borrowOut;
            r_zero  <= (w_nextShift == '0);
            r_neg   <= r_signed ? w_resMsb : w_borrowOut;
            r_ovf   <= r_signed ? ((r_aMsb != r_bMsb) && (w_resMsb != r_aMsb)) : w_borrowOut;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.zero = r_zero;
  assign bus.neg  = r_neg;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor.
// It uses an 8-bit, 1-bit-digit instance for directed vectors and handshake
// corners, and a 16-bit, 4-bit-digit instance for randomized vectors.
// Both are compared against an arithmetic reference model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  typedef struct {
    string    name;
    logic [7:0] a;
    logic [7:0] b;
    logic     bin;
    logic     sm;
    logic [7:0] diff;
    logic     bout;
    logic     zero;
    logic     neg;
    logic     ovf;
  } vec_t;

  vec_t vecs [8];

  // Golden result from plain integer arithmetic on the operands.
  function automatic res_t refModel(input int w, input longint a, input longint b,
                                    input logic bin, input logic sm);
    res_t   r;
    longint full, mask, dv;
    logic   am, bm, dm;
    mask   = (longint'(1) << w) - 1;
    full   = a - b - longint'(bin);
    dv     = full & mask;
    r.diff = 32'(dv);
    r.bout = (full < 0);
    r.zero = (dv == 0);
    am     = ((a >> (w - 1)) & 1) != 0;
    bm     = ((b >> (w - 1)) & 1) != 0;
    dm     = ((dv >> (w - 1)) & 1) != 0;
    if (sm) begin
      r.neg = dm;
      r.ovf = (am != bm) && (dm != am);
    end else begin
      r.neg = r.bout;
      r.ovf = r.bout;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdBusy(input int which);
    return (which == 0) ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic rdDone(input int which);
    return (which == 0) ? bus8.done : bus16.done;
  endfunction

  function automatic res_t rdRes(input int which);
    res_t r;
    if (which == 0) begin
      r.diff = 32'(bus8.diff);
      r.bout = bus8.bout;
      r.zero = bus8.zero;
      r.neg  = bus8.neg;
      r.ovf  = bus8.ovf;
    end else begin
      r.diff = 32'(bus16.diff);
      r.bout = bus16.bout;
      r.zero = bus16.zero;
      r.neg  = bus16.neg;
      r.ovf  = bus16.ovf;
    end
    return r;
  endfunction

  task automatic driveOp(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic sm);
    if (which == 0) begin
      bus8.start       = 1'b1;
      bus8.a           = a[7:0];
      bus8.b           = b[7:0];
      bus8.bin         = bin;
      bus8.signed_mode = sm;
    end else begin
      bus16.start       = 1'b1;
      bus16.a           = a;
      bus16.b           = b;
      bus16.bin         = bin;
      bus16.signed_mode = sm;
    end
  endtask

  // Pulse start for one edge and confirm that the operation was accepted.
  task automatic applyStimulus(input int which, input logic [15:0] a, input logic [15:0] b,
                               input logic bin, input logic sm);
    driveOp(which, a, b, bin, sm);
    tick();
    if (which == 0) bus8.start = 1'b0;
    else            bus16.start = 1'b0;
    checkOutput("accept busy", 32'(rdBusy(which)), 32'd1);
  endtask

  // Count edges until done, with a bounded wait.
  task automatic waitDone(input int which, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 64 && !seen) begin
      tick();
      cyc++;
      seen = rdDone(which);
    end
    if (!seen) checkOutput("done timeout", 32'd0, 32'd1);
  endtask

  task automatic checkRes(input string tag, input res_t got, input res_t exp);
    checkOutput({tag, " diff"}, got.diff, exp.diff);
    checkOutput({tag, " bout"}, 32'(got.bout), 32'(exp.bout));
    checkOutput({tag, " zero"}, 32'(got.zero), 32'(exp.zero));
    checkOutput({tag, " neg"},  32'(got.neg),  32'(exp.neg));
    checkOutput({tag, " ovf"},  32'(got.ovf),  32'(exp.ovf));
  endtask

  task automatic runOp(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic sm, input string tag);
    int   cyc;
    res_t exp;
    applyStimulus(which, a, b, bin, sm);
    waitDone(which, cyc);
    checkOutput({tag, " latency"}, 32'(cyc), (which == 0) ? 32'd8 : 32'd4);
    exp = refModel((which == 0) ? 8 : 16, longint'(a), longint'(b), bin, sm);
    checkRes(tag, rdRes(which), exp);
    tick();
    checkOutput({tag, " done pulse width"}, 32'(rdDone(which)), 32'd0);
  endtask

  task automatic countDones(input int which, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rdDone(which)) cnt++;
    end
  endtask

  initial begin
    int   cyc;
    int   cnt;
    res_t exp;
    logic [15:0] ra, rb;
    logic rbin, rsm;

    vecs[0] = '{"u 05-03",     8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"u 03-05",     8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"u 00-00-1",   8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"s 80-01",     8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"s 10-10",     8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"s 7F-FF",     8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{"s FF-FF-1",   8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"u 00-00",     8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.bin = 1'b0;  bus8.signed_mode = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0; bus16.signed_mode = 1'b0;
    tick();
    tick();

    // Reset values
    checkOutput("reset busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset done", 32'(bus8.done), 32'd0);
    checkRes("reset", rdRes(0), '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    checkOutput("reset diff16", 32'(bus16.diff), 32'd0);

    // rst and start together: rst wins
    driveOp(0, 16'h0005, 16'h0001, 1'b0, 1'b0);
    tick();
    bus8.start = 1'b0;
    checkOutput("rst+start busy", 32'(bus8.busy), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("start dropped busy", 32'(bus8.busy), 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      applyStimulus(0, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].bin, vecs[i].sm);
      waitDone(0, cyc);
      checkOutput({vecs[i].name, " latency"}, 32'(cyc), 32'd8);
      checkRes(vecs[i].name, rdRes(0),
               '{32'(vecs[i].diff), vecs[i].bout, vecs[i].zero, vecs[i].neg, vecs[i].ovf});
      tick();
    end

    // Start while busy: ignored, operands undisturbed, outputs held
    applyStimulus(0, 16'h0040, 16'h0013, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("hold diff while busy", 32'(bus8.diff), 32'h00);
    checkOutput("hold zero while busy", 32'(bus8.zero), 32'd1);
    driveOp(0, 16'h00AA, 16'h0000, 1'b1, 1'b1);
    tick();
    bus8.start = 1'b0;
    waitDone(0, cyc);
    checkOutput("busy start latency", 32'(cyc + 3), 32'd8);
    checkRes("busy start", rdRes(0), '{32'h2D, 1'b0, 1'b0, 1'b0, 1'b0});
    countDones(0, 12, cnt);
    checkOutput("ignored start no done", 32'(cnt), 32'd0);

    // Back-to-back with start held high through done
    driveOp(0, 16'h0009, 16'h0004, 1'b0, 1'b0);
    tick();
    checkOutput("b2b first busy", 32'(bus8.busy), 32'd1);
    waitDone(0, cyc);
    checkOutput("b2b first latency", 32'(cyc), 32'd8);
    checkOutput("b2b first diff", 32'(bus8.diff), 32'h05);
    bus8.a = 8'h01;
    bus8.b = 8'h02;
    tick();
    bus8.start = 1'b0;
    checkOutput("b2b second accept", 32'(bus8.busy), 32'd1);
    checkOutput("b2b done cleared", 32'(bus8.done), 32'd0);
    waitDone(0, cyc);
    checkOutput("b2b second latency", 32'(cyc), 32'd8);
    checkRes("b2b second", rdRes(0), '{32'hFF, 1'b1, 1'b0, 1'b1, 1'b1});
    tick();

    // Reset four clocks after acceptance
    applyStimulus(0, 16'h0020, 16'h0001, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst busy", 32'(bus8.busy), 32'd0);
    checkOutput("midrst done", 32'(bus8.done), 32'd0);
    checkRes("midrst", rdRes(0), '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    countDones(0, 12, cnt);
    checkOutput("midrst no done", 32'(cnt), 32'd0);
    runOp(0, 16'h0020, 16'h0001, 1'b0, 1'b0, "after reset");

    // Randomized 8-bit, 1-bit digit
    for (int i = 0; i < 200; i++) begin
      ra   = 16'($urandom_range(0, 255));
      rb   = 16'($urandom_range(0, 255));
      rbin = 1'($urandom);
      rsm  = 1'($urandom);
      runOp(0, ra, rb, rbin, rsm, "rand8");
    end

    // Randomized 16-bit, 4-bit digit
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      rsm  = 1'($urandom);
      runOp(1, ra, rb, rbin, rsm, "rand16");
    end

    // 16-bit extremes
    runOp(1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, "x16 0-FFFF-1");
    runOp(1, 16'h8000, 16'h0001, 1'b0, 1'b1, "x16 8000-1");
    exp = refModel(16, longint'(16'h1234), longint'(16'h1234), 1'b0, 1'b1);
    runOp(1, 16'h1234, 16'h1234, 1'b0, 1'b1, "x16 equal");
    checkOutput("x16 equal zero model", 32'(bus16.zero), 32'(exp.zero));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
